// File: rtl/ram_pkg.sv
// Shared definitions for the RAM burst initiator: default widths and the FSM state type.
package ram_pkg;
    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } burst_state_t;
endpackage

// File: rtl/ram_burst_ctrl_if.sv
// Bundle of command, write-data, read-data, status and RAM pins around ram_burst_ctrl.
// Handshakes: a word moves on a clock edge where valid and ready are both high; valid never waits on ready.
interface ram_burst_ctrl_if #(
    parameter int ADDR_W = ram_pkg::RAM_ADDR_W,
    parameter int DATA_W = ram_pkg::RAM_DATA_W
) ();
    import ram_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;
    burst_state_t      dbg_state;

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
        output ram_ena, ram_wena, ram_addr, ram_data_in, dbg_state
    );

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_data_out,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
        input  ram_ena, ram_wena, ram_addr, ram_data_in, dbg_state
    );
endinterface

// File: rtl/ram_burst_ctrl_rd_fifo2.sv
// Two-entry read-data FIFO (module ram_rd_fifo2) with occupancy output and synchronous flush.
module ram_rd_fifo2 #(
    parameter int DATA_W = ram_pkg::RAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_occ;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            r_occ  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (i_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // Head is masked when empty so stale words never leak onto rd_data.
    assign o_data = (r_occ != 2'd0) ? r_mem[r_rptr] : '0;
    assign o_occ  = r_occ;
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst initiator for the 32x32 single-port ram: write bursts stream in, read bursts stream out via a 2-deep FIFO.
// Optional RAM_BURST_BOUND_EN rejects bursts that would cross the top address and pulses err instead.
module ram_burst_ctrl #(
    parameter int ADDR_W = ram_pkg::RAM_ADDR_W,
    parameter int DATA_W = ram_pkg::RAM_DATA_W
) (
    input logic               clk,
    input logic               rst,
    ram_burst_ctrl_if.slave   bus
);
    import ram_pkg::*;

    burst_state_t      r_state;
    burst_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_rem;
    logic [ADDR_W:0]   r_to_issue;
    logic [ADDR_W:0]   r_to_pop;
    logic              r_inflight;
    logic              r_done;

    logic              w_cmd_fire;
    logic              w_wr_fire;
    logic              w_issue;
    logic              w_fin;
    logic              w_pop;
    logic              w_room;
    logic              w_bound_bad;
    logic [1:0]        w_occ;
    logic [DATA_W-1:0] w_fifo_data;

`ifdef RAM_BURST_BOUND_EN
    logic              r_err;
    logic              w_reject;
    logic [ADDR_W:0]   w_end;
    assign w_end       = {1'b0, bus.cmd_addr} + {1'b0, bus.cmd_len};
    assign w_bound_bad = w_end[ADDR_W];
    assign w_reject    = (r_state == IDLE) && bus.cmd_valid && w_bound_bad;
    always_ff @(posedge clk) begin
        if (rst) r_err <= 1'b0;
        else     r_err <= w_reject;
    end
    assign bus.err = r_err;
`else
    assign w_bound_bad = 1'b0;
    assign bus.err     = 1'b0;
`endif

    assign bus.rd_valid = (w_occ != 2'd0);
    assign w_pop        = bus.rd_valid && bus.rd_ready;
    // occ + inflight - pop < 2, rearranged to stay unsigned.
    assign w_room       = ({1'b0, w_occ} + {2'b0, r_inflight}) < (3'd2 + {2'b0, w_pop});

    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_fire    = 1'b0;
        w_wr_fire     = 1'b0;
        w_issue       = 1'b0;
        w_fin         = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.wr_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid && !w_bound_bad) begin
                    w_cmd_fire  = 1'b1;
                    w_state_nxt = bus.cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                bus.wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    w_wr_fire = 1'b1;
                    if (r_rem == '0) begin
                        w_fin       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            end
            READ: begin
                w_issue = (r_to_issue != '0) && w_room;
                if (w_pop && (r_to_pop == (ADDR_W+1)'(1))) begin
                    w_fin       = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_to_issue <= '0;
            r_to_pop   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_fin;
            r_inflight <= w_issue;
            if (w_cmd_fire) begin
                r_addr     <= bus.cmd_addr;
                r_rem      <= bus.cmd_len;
                r_to_issue <= {1'b0, bus.cmd_len} + 1'b1;
                r_to_pop   <= {1'b0, bus.cmd_len} + 1'b1;
            end else begin
                if (w_wr_fire || w_issue) r_addr <= r_addr + 1'b1;
                if (w_wr_fire)            r_rem <= r_rem - 1'b1;
                if (w_issue)              r_to_issue <= r_to_issue - 1'b1;
                if (w_pop)                r_to_pop <= r_to_pop - 1'b1;
            end
        end
    end

    ram_rd_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_cmd_fire),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  (bus.ram_data_out),
        .o_data  (w_fifo_data),
        .o_occ   (w_occ)
    );

    assign bus.rd_data     = w_fifo_data;
    assign bus.ram_ena     = w_wr_fire || w_issue;
    assign bus.ram_wena    = w_wr_fire;
    assign bus.ram_addr    = bus.ram_ena ? r_addr : '0;
    assign bus.ram_data_in = w_wr_fire ? bus.wr_data : '0;
    assign bus.busy        = (r_state != IDLE);
    assign bus.done        = r_done;
    assign bus.dbg_state   = r_state;
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl with a behavioural 32x32 RAM and a shadow-memory scoreboard.
module tb_ram_burst_ctrl;
    import ram_pkg::*;

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [4:0]  len;
        logic [31:0] dbase;
        bit          toggle;
        int          exp_first;
        int          exp_last;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] ram_mem [32];
    logic [31:0] exp_mem [32];
    logic [31:0] exp_q [$];
    vec_t        vecs [8];

    ram_burst_ctrl_if bus ();

    ram_burst_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM; poison stands in for high-Z whenever ena is low.
    always @(posedge clk) begin
        if (bus.ram_ena) begin
            if (bus.ram_wena) ram_mem[bus.ram_addr] <= bus.ram_data_in;
            else              bus.ram_data_out <= ram_mem[bus.ram_addr];
        end else begin
            bus.ram_data_out <= 32'hDEAD_BEEF;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue_cmd(input bit wr, input logic [4:0] a, input logic [4:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        #1;
        check("cmd_ready_idle", bus.cmd_ready, 1);
        check("no_access_idle", bus.ram_ena, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_write(input logic [4:0] a, input logic [4:0] l, input logic [31:0] dbase,
                             input int exp_first, input int exp_last);
        logic [4:0]  wa;
        logic [31:0] wd;
        int first;
        int last;
        first = 0;
        last  = 0;
        issue_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            wa = a + 5'(i);
            wd = dbase + 32'(i);
            bus.wr_valid = 1'b1;
            bus.wr_data  = wd;
            #1;
            check("wr_ready", bus.wr_ready, 1);
            check("wr_wena", bus.ram_wena, 1);
            check("wr_addr", bus.ram_addr, wa);
            check("wr_data_in", bus.ram_data_in, wd);
            if (bus.ram_ena && bus.ram_wena) begin
                if (first == 0) first = i + 1;
                last = i + 1;
            end
            exp_mem[wa] = wd;
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        #1;
        check("wr_done_pulse", bus.done, 1);
        check("wr_busy_after", bus.busy, 0);
        check("wr_err_low", bus.err, 0);
        check("wr_idle_no_access", bus.ram_ena, 0);
        check("wr_first_cycle", first, exp_first);
        check("wr_last_cycle", last, exp_last);
        @(negedge clk);
        #1;
        check("wr_done_one_cycle", bus.done, 0);
        @(negedge clk);
    endtask

    // Starts in the first cycle after the accepting edge.
    task automatic drain_read(input logic [4:0] a, input logic [4:0] l, input bit toggle,
                              input int exp_first, input int exp_last);
        int cyc;
        int issued;
        int popped;
        int first;
        int last;
        bit pop;
        bit exp_issue;
        logic [4:0] ea;
        cyc = 1; issued = 0; popped = 0; first = 0; last = 0;
        exp_q.delete();
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 5'(i);
            exp_q.push_back(exp_mem[ea]);
        end
        while (popped <= int'(l) && cyc < 200) begin
            bus.rd_ready = toggle ? cyc[0] : 1'b1;
            #1;
            pop       = bus.rd_valid && bus.rd_ready;
            exp_issue = (issued <= int'(l)) && ((issued - popped - int'(pop)) < 2);
            check("rd_issue", bus.ram_ena, exp_issue);
            if (bus.ram_ena) begin
                ea = a + 5'(issued);
                check("rd_wena", bus.ram_wena, 0);
                check("rd_addr", bus.ram_addr, ea);
                issued++;
            end
            if (pop) begin
                if (first == 0) first = cyc;
                last = cyc;
                if (exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q.pop_front());
                popped++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rd_ready = 1'b0;
        #1;
        check("rd_word_count", popped, int'(l) + 1);
        check("rd_done_pulse", bus.done, 1);
        check("rd_busy_after", bus.busy, 0);
        check("rd_valid_after", bus.rd_valid, 0);
        if (exp_first != 0) check("rd_first_valid_cycle", first, exp_first);
        if (exp_last != 0)  check("rd_last_pop_cycle", last, exp_last);
        @(negedge clk);
        #1;
        check("rd_done_one_cycle", bus.done, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        vecs[0] = '{1'b1, 5'd0,  5'd31, 32'h5500_0000, 1'b0, 1, 32};
        vecs[1] = '{1'b1, 5'd3,  5'd3,  32'h0000_00A0, 1'b0, 1, 4};
        vecs[2] = '{1'b0, 5'd3,  5'd3,  32'h0,         1'b0, 3, 6};
        vecs[3] = '{1'b0, 5'd3,  5'd7,  32'h0,         1'b1, 3, 0};
        vecs[4] = '{1'b0, 5'd5,  5'd0,  32'h0,         1'b0, 3, 3};
        vecs[5] = '{1'b1, 5'd31, 5'd0,  32'h0000_00EE, 1'b0, 1, 1};
        vecs[6] = '{1'b0, 5'd31, 5'd0,  32'h0,         1'b0, 3, 3};
        vecs[7] = '{1'b0, 5'd0,  5'd31, 32'h0,         1'b0, 3, 34};

        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1234_5678;
        #1;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_wr_ready", bus.wr_ready, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_ram_ena", bus.ram_ena, 0);
        check("rst_ram_wena", bus.ram_wena, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_data_in", bus.ram_data_in, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_state", bus.dbg_state, IDLE);
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            if (vecs[v].wr) begin
                run_write(vecs[v].addr, vecs[v].len, vecs[v].dbase, vecs[v].exp_first, vecs[v].exp_last);
            end else begin
                issue_cmd(1'b0, vecs[v].addr, vecs[v].len);
                drain_read(vecs[v].addr, vecs[v].len, vecs[v].toggle, vecs[v].exp_first, vecs[v].exp_last);
            end
        end

`ifdef RAM_BURST_BOUND_EN
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 5'd30; bus.cmd_len = 5'd2;
        #1;
        check("bound_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        check("bound_err_pulse", bus.err, 1);
        check("bound_no_done", bus.done, 0);
        check("bound_idle", bus.busy, 0);
        check("bound_no_access", bus.ram_ena, 0);
        @(negedge clk);
        #1;
        check("bound_err_one_cycle", bus.err, 0);
        @(negedge clk);
`else
        run_write(5'd30, 5'd2, 32'h0000_00B0, 1, 3);
        issue_cmd(1'b0, 5'd30, 5'd2);
        drain_read(5'd30, 5'd2, 1'b0, 3, 5);
`endif

        // Reset two cycles into a 16-word read.
        issue_cmd(1'b0, 5'd0, 5'd15);
        bus.rd_ready = 1'b1;
        #1;
        @(negedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_rd_valid", bus.rd_valid, 0);
        check("abort_ram_ena", bus.ram_ena, 0);
        check("abort_no_done", bus.done, 0);
        check("abort_state", bus.dbg_state, IDLE);
        @(negedge clk);
        bus.rd_ready = 1'b0;
        #1;
        check("abort_no_done_late", bus.done, 0);
        run_write(5'd20, 5'd1, 32'h0000_00D0, 1, 2);

        // Command held through a write burst is taken in the done cycle.
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 5'd8; bus.cmd_len = 5'd2;
        #1;
        check("hold_first_ready", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_write = 1'b0; bus.cmd_addr = 5'd3; bus.cmd_len = 5'd1;
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'h0000_00C0 + 32'(i);
            #1;
            check("hold_cmd_ready_low", bus.cmd_ready, 0);
            check("hold_state_write", bus.dbg_state, WRITE);
            check("hold_wr_addr", bus.ram_addr, 32'(8 + i));
            exp_mem[8 + i] = 32'h0000_00C0 + 32'(i);
            @(negedge clk);
        end
        bus.wr_valid = 1'b0;
        #1;
        check("hold_done", bus.done, 1);
        check("hold_ready_at_done", bus.cmd_ready, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        drain_read(5'd3, 5'd1, 1'b0, 3, 4);

        // Contents written before the aborted read survive.
        issue_cmd(1'b0, 5'd3, 5'd7);
        drain_read(5'd3, 5'd7, 1'b0, 3, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
